// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// store_buffer
// Decouples S-type stores from the data memory. Accepted stores are aligned
// into a word address, lane-replicated data and shifted byte enables, queued
// in a DEPTH-entry circular buffer and retired in order through a two-state
// request/acknowledge handshake. Misaligned or illegal stores are dropped and
// reported. A load-address comparator flags pending stores to the same word.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   st_valid/st_ready    store handshake (ready while the buffer is not full)
//   st_addr, st_data     store byte address, right-justified store data
//   st_wr_en             size code: 0001 byte, 0011 half, 1111 word, 0000 none
//   st_err, err_addr     one-cycle fault pulse and address of the last fault
//   mem_req/mem_ack      memory write handshake, ack completes the write
//   mem_addr/wdata/be    head entry presented for the duration of a request
//   ld_addr, ld_hit      load hazard check against all buffered entries
//   sb_empty             nothing buffered and no request outstanding
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [3:0]  st_wr_en,
  output logic        st_ready,
  output logic        st_err,
  output logic [31:0] err_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [1:0] CLS_NOP = 2'b00;
  localparam logic [1:0] CLS_OK  = 2'b01;
  localparam logic [1:0] CLS_BAD = 2'b10;

  // Returns {class, byte_enable, lane_data} for one store request.
  function automatic logic [37:0] classify_store(input logic [3:0]  wr_en,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] d);
    logic [1:0]  kind;
    logic [3:0]  be;
    logic [31:0] data;
    kind = CLS_BAD;
    be   = 4'b0000;
    data = 32'h0000_0000;
    case (wr_en)
      4'b0001: begin
        kind = CLS_OK;
        be   = 4'b0001 << lo;
        data = {4{d[7:0]}};
      end
      4'b0011: begin
        if (lo[0] == 1'b0) begin
          kind = CLS_OK;
          be   = 4'b0011 << lo;
          data = {2{d[15:0]}};
        end else begin
          kind = CLS_BAD;
        end
      end
      4'b1111: begin
        if (lo == 2'b00) begin
          kind = CLS_OK;
          be   = 4'b1111;
          data = d;
        end else begin
          kind = CLS_BAD;
        end
      end
      4'b0000: kind = CLS_NOP;
      default: kind = CLS_BAD;
    endcase
    return {kind, be, data};
  endfunction

  logic [0:0]       state_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [DEPTH-1:0] vld_r;
  logic [29:0]      ent_addr_r [DEPTH];
  logic [31:0]      ent_data_r [DEPTH];
  logic [3:0]       ent_be_r   [DEPTH];

  logic             mem_req_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic [3:0]       mem_be_r;
  logic             st_err_r;
  logic [31:0]      err_addr_r;

  logic [37:0]      cls_s;
  logic [1:0]       kind_s;
  logic [3:0]       new_be_s;
  logic [31:0]      new_data_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             fault_s;
  logic [DEPTH-1:0] set_mask_s;
  logic [DEPTH-1:0] clr_mask_s;
  logic             hit_s;
  logic             unused_s;

  assign cls_s      = classify_store(st_wr_en, st_addr[1:0], st_data);
  assign kind_s     = cls_s[37:36];
  assign new_be_s   = cls_s[35:32];
  assign new_data_s = cls_s[31:0];

  assign st_ready = (count_r != CNT_FULL);
  assign accept_s = st_valid & st_ready;
  assign push_s   = accept_s & (kind_s == CLS_OK);
  assign fault_s  = accept_s & (kind_s == CLS_BAD);
  // Pops only from REQ; count is at least one there so the buffer never underflows.
  assign pop_s    = (state_r == ST_REQ) & mem_ack;

  assign set_mask_s = push_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << tail_r) : {DEPTH{1'b0}};
  assign clr_mask_s = pop_s  ? ({{(DEPTH-1){1'b0}}, 1'b1} << head_r) : {DEPTH{1'b0}};

  // Hazard check across all occupied entries; the head stays occupied until acked.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (vld_r[i] & (ent_addr_r[i] == ld_addr[31:2]));
    end
  end

  assign ld_hit   = hit_s;
  assign unused_s = ^ld_addr[1:0];

  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;
  assign st_err    = st_err_r;
  assign err_addr  = err_addr_r;
  assign sb_empty  = (count_r == CNT_ZERO) & (state_r == ST_IDLE);

  // Entry payload; qualified by vld_r, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ent_addr_r[tail_r] <= st_addr[31:2];
      ent_data_r[tail_r] <= new_data_s;
      ent_be_r[tail_r]   <= new_be_s;
    end
  end

  // Pointers, occupancy count and per-entry valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= CNT_ZERO;
      vld_r   <= {DEPTH{1'b0}};
    end else begin
      vld_r <= (vld_r | set_mask_s) & ~clr_mask_s;
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Fault reporting: single-cycle pulse, address held until the next fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_err_r   <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else begin
      st_err_r <= fault_s;
      if (fault_s) begin
        err_addr_r <= st_addr;
      end
    end
  end

  // Memory-side FSM; the head entry is latched on entry to REQ so the
  // request fields stay stable even while new stores are being enqueued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (count_r != CNT_ZERO) begin
            state_r     <= ST_REQ;
            mem_req_r   <= 1'b1;
            mem_addr_r  <= {ent_addr_r[head_r], 2'b00};
            mem_wdata_r <= ent_data_r[head_r];
            mem_be_r    <= ent_be_r[head_r];
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for store_buffer: a transaction-level queue model is
// compared against the DUT every cycle, with directed scenarios and literal
// expectations followed by randomized traffic.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_wr_en;
  logic        st_ready;
  logic        st_err;
  logic [31:0] err_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        sb_empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_wr_en(st_wr_en),
    .st_ready(st_ready), .st_err(st_err), .err_addr(err_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .ld_addr(ld_addr), .ld_hit(ld_hit), .sb_empty(sb_empty)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 0;

  ent_t        mq[$];
  bit          m_busy;
  ent_t        m_exp;
  bit          m_err;
  logic [31:0] m_err_addr;
  logic [31:0] obs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    bit h = 1'b0;
    foreach (mq[i]) begin
      if (mq[i].addr[31:2] == a[31:2]) h = 1'b1;
    end
    return h;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_busy     = 1'b0;
    m_err      = 1'b0;
    m_err_addr = 32'h0;
  endtask

  // Called right after a rising edge, while the inputs still hold the values sampled there.
  task automatic model_update();
    bit   acc;
    int   sz;
    int   off;
    ent_t e;
    acc = st_valid && (mq.size() != DEPTH);
    if (m_busy) begin
      if (mem_ack) begin
        mq.delete(0);
        m_busy = 1'b0;
      end
    end else if (mq.size() != 0) begin
      m_busy = 1'b1;
      m_exp  = mq[0];
    end
    m_err = 1'b0;
    if (acc) begin
      case (st_wr_en)
        4'b0001: sz = 1;
        4'b0011: sz = 2;
        4'b1111: sz = 4;
        4'b0000: sz = 0;
        default: sz = -1;
      endcase
      off = int'(st_addr[1:0]);
      if (sz > 0 && (off % sz) == 0) begin
        e.addr = st_addr & 32'hFFFF_FFFC;
        e.be   = 4'(((1 << sz) - 1) << off);
        if (sz == 1)      e.data = 32'(st_data[7:0])  * 32'h0101_0101;
        else if (sz == 2) e.data = 32'(st_data[15:0]) * 32'h0001_0001;
        else              e.data = st_data;
        mq.push_back(e);
      end else if (sz != 0) begin
        m_err      = 1'b1;
        m_err_addr = st_addr;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_wr_en = w;
  endtask

  task automatic drain();
    st_valid = 1'b0;
    mem_ack  = 1'b1;
    repeat (2 * DEPTH + 4) cyc();
    mem_ack = 1'b0;
    cyc();
  endtask

  // Per-cycle comparison of every output against the queue model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("st_ready", st_ready, mq.size() != DEPTH);
      chk("sb_empty", sb_empty, (mq.size() == 0) && !m_busy);
      chk("mem_req", mem_req, m_busy);
      chk("st_err", st_err, m_err);
      chk("err_addr", err_addr, m_err_addr);
      chk("ld_hit", ld_hit, model_hit(ld_addr));
      if (m_busy) begin
        chk("mem_addr", mem_addr, m_exp.addr);
        chk("mem_wdata", mem_wdata, m_exp.data);
        chk("mem_be", mem_be, m_exp.be);
      end
      if (mem_req && mem_ack) obs.push_back(mem_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; st_valid = 1'b0; st_addr = 32'h0; st_data = 32'h0;
    st_wr_en = 4'b0000; mem_ack = 1'b0; ld_addr = 32'h0;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    // Reset values appear before any clock edge.
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_sb_empty", sb_empty, 1'b1);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_st_err", st_err, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", mem_be, 4'b0000);
    chk("rst_ld_hit", ld_hit, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Byte store at 0x1003.
    drive_st(32'h0000_1003, 32'h0000_00AB, 4'b0001);
    cyc();
    st_valid = 1'b0;
    chk("byte_req_edge1", mem_req, 1'b0);
    cyc();
    chk("byte_req_edge2", mem_req, 1'b1);
    chk("byte_addr", mem_addr, 32'h0000_1000);
    chk("byte_be", mem_be, 4'b1000);
    chk("byte_wdata", mem_wdata, 32'hABAB_ABAB);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    chk("byte_req_done", mem_req, 1'b0);
    cyc();
    chk("byte_empty", sb_empty, 1'b1);

    // Misaligned half store.
    drive_st(32'h0000_2001, 32'h0000_1234, 4'b0011);
    cyc();
    st_valid = 1'b0;
    chk("half_err_pulse", st_err, 1'b1);
    chk("half_err_addr", err_addr, 32'h0000_2001);
    chk("half_empty", sb_empty, 1'b1);
    cyc();
    chk("half_err_clear", st_err, 1'b0);
    chk("half_empty2", sb_empty, 1'b1);
    chk("half_no_req", mem_req, 1'b0);

    // Five word stores, ack held low: fill, back-pressure, then ordered drain.
    obs.delete();
    for (int i = 0; i < 4; i++) begin
      drive_st(32'h0000_4000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'b1111);
      cyc();
    end
    chk("full_not_ready", st_ready, 1'b0);
    drive_st(32'h0000_4010, 32'hC0DE_0004, 4'b1111);
    repeat (3) cyc();
    chk("full_still_blocked", st_ready, 1'b0);
    chk("full_no_err", st_err, 1'b0);
    chk("full_head_addr", mem_addr, 32'h0000_4000);
    mem_ack = 1'b1;
    begin
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 12 && !acc; k++) begin
        acc = st_ready;
        cyc();
      end
      st_valid = 1'b0;
      chk("fifth_accepted", acc, 1'b1);
    end
    repeat (14) cyc();
    mem_ack = 1'b0;
    cyc();
    chk("order_count", obs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("order_addr", (i < obs.size()) ? obs[i] : 32'hFFFF_FFFF, 32'h0000_4000 + 32'(i * 4));
    end

    // Push on the same edge as a pop with two entries buffered.
    drive_st(32'h0000_6000, 32'h1111_1111, 4'b1111);
    cyc();
    drive_st(32'h0000_6004, 32'h2222_2222, 4'b1111);
    cyc();
    chk("pp_in_req", mem_req, 1'b1);
    drive_st(32'h0000_6008, 32'h3333_3333, 4'b1111);
    mem_ack = 1'b1;
    cyc();
    st_valid = 1'b0;
    mem_ack  = 1'b0;
    chk("pp_count", dut.count_r, 32'd2);
    chk("pp_model_count", mq.size(), 2);
    chk("pp_ready", st_ready, 1'b1);
    ld_addr = 32'h0000_6000; #1;
    chk("pp_hit_popped", ld_hit, 1'b0);
    ld_addr = 32'h0000_6004; #1;
    chk("pp_hit_b", ld_hit, 1'b1);
    ld_addr = 32'h0000_6008; #1;
    chk("pp_hit_c", ld_hit, 1'b1);
    cyc();
    chk("pp_next_head", mem_addr, 32'h0000_6004);
    drain();

    // Load hazard against a buffered word store.
    drive_st(32'h0000_3008, 32'hDEAD_BEEF, 4'b1111);
    cyc();
    st_valid = 1'b0;
    ld_addr = 32'h0000_300B; #1;
    chk("ld_same_word", ld_hit, 1'b1);
    ld_addr = 32'h0000_300C; #1;
    chk("ld_next_word", ld_hit, 1'b0);
    cyc();
    ld_addr = 32'h0000_300B; #1;
    chk("ld_head_in_req", ld_hit, 1'b1);
    drain();
    chk("ld_after_drain", ld_hit, 1'b0);

    // Reset in the middle of a request with three entries buffered.
    for (int i = 0; i < 3; i++) begin
      drive_st(32'h0000_7000 + 32'(i * 4), 32'h7777_0000 + 32'(i), 4'b1111);
      cyc();
    end
    st_valid = 1'b0;
    cyc();
    chk("rr_in_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    ld_addr = 32'h0000_7000;
    #1;
    chk("rr_req_async", mem_req, 1'b0);
    chk("rr_empty_async", sb_empty, 1'b1);
    chk("rr_ready_async", st_ready, 1'b1);
    chk("rr_hit_cleared", ld_hit, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    cyc();
    cyc();
    chk("rr_late_ack_req", mem_req, 1'b0);
    chk("rr_late_ack_empty", sb_empty, 1'b1);
    mem_ack = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int sel;
      st_valid = ($urandom_range(0, 9) < 6);
      st_addr  = 32'h0000_5000 + ($urandom_range(0, 7) * 32'd4) + $urandom_range(0, 3);
      st_data  = $urandom();
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: st_wr_en = 4'b0001;
        3, 4:    st_wr_en = 4'b0011;
        5, 6:    st_wr_en = 4'b1111;
        7:       st_wr_en = 4'b0000;
        default: st_wr_en = 4'($urandom());
      endcase
      mem_ack = ($urandom_range(0, 1) == 1);
      ld_addr = 32'h0000_5000 + ($urandom_range(0, 7) * 32'd4) + $urandom_range(0, 3);
      cyc();
    end
    drain();
    chk("final_empty", sb_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
